// File: rtl/comparador_pkg.sv
// Shared types for the guessing-round comparator: FSM states and the
// three-way classification of a guess against the secret.
package comparador_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        JOGANDO,
        GANHOU,
        PERDEU
    } estado_t;

    typedef enum logic [1:0] {
        IGUAL,
        PERTO,
        ERRADA
    } classe_t;

endpackage

// File: rtl/comparador_dist.sv
// Purely combinational distance classifier: compares a guess with the secret
// without wrap-around and reports equal / near / wrong plus the direction.
module comparador_dist
    import comparador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int TOL   = 3
) (
    input  logic [WIDTH-1:0] segredo,
    input  logic [WIDTH-1:0] palpite,
    output logic             igual,
    output logic             perto,
    output logic             errada,
    output logic             maior
);

    localparam logic [WIDTH:0] TOL_EXT = (WIDTH+1)'(TOL);

    logic signed [WIDTH:0] diferenca;
    logic [WIDTH-1:0]      distancia;
    classe_t               classe;

    // One extra bit keeps the subtraction exact, so 0 vs all-ones is far apart.
    always_comb begin
        diferenca = $signed({1'b0, palpite}) - $signed({1'b0, segredo});
        distancia = diferenca[WIDTH] ? WIDTH'(-diferenca) : WIDTH'(diferenca);

        if (distancia == '0) begin
            classe = IGUAL;
        end else if ({1'b0, distancia} <= TOL_EXT) begin
            classe = PERTO;
        end else begin
            classe = ERRADA;
        end

        maior  = (palpite > segredo);
        igual  = (classe == IGUAL);
        perto  = (classe == PERTO);
        errada = (classe == ERRADA);
    end

endmodule

// File: rtl/comparador_rodada.sv
// One round of a guessing game: latches a secret, classifies each guess one
// cycle later and ends the round on a hit or after MAX_TENT attempts.
module comparador_rodada
    import comparador_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int TOL      = 3,
    parameter int MAX_TENT = 7
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             nova_rodada,
    input  logic [WIDTH-1:0]                 segredo,
    input  logic                             valido,
    input  logic [WIDTH-1:0]                 palpite,
    output logic                             res_valido,
    output logic                             igual,
    output logic                             perto,
    output logic                             errada,
    output logic                             maior,
    output logic [$clog2(MAX_TENT+1)-1:0]    tentativas,
    output logic                             fim,
    output logic                             venceu
);

    localparam int             CW       = $clog2(MAX_TENT + 1);
    localparam logic [CW-1:0]  TENT_MAX = CW'(MAX_TENT);

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] segredo_q, segredo_d;
    logic             igual_q, igual_d;
    logic             perto_q, perto_d;
    logic             errada_q, errada_d;
    logic             maior_q, maior_d;
    logic [CW-1:0]    tentativas_q, tentativas_d;
    logic             res_valido_q, res_valido_d;

    logic dist_igual, dist_perto, dist_errada, dist_maior;

    comparador_dist #(
        .WIDTH (WIDTH),
        .TOL   (TOL)
    ) u_dist (
        .segredo (segredo_q),
        .palpite (palpite),
        .igual   (dist_igual),
        .perto   (dist_perto),
        .errada  (dist_errada),
        .maior   (dist_maior)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= OCIOSO;
            segredo_q    <= '0;
            igual_q      <= 1'b0;
            perto_q      <= 1'b0;
            errada_q     <= 1'b0;
            maior_q      <= 1'b0;
            tentativas_q <= '0;
            res_valido_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            segredo_q    <= segredo_d;
            igual_q      <= igual_d;
            perto_q      <= perto_d;
            errada_q     <= errada_d;
            maior_q      <= maior_d;
            tentativas_q <= tentativas_d;
            res_valido_q <= res_valido_d;
        end
    end

    // A new round always takes priority, discarding any guess in the same cycle.
    always_comb begin
        estado_d     = estado_q;
        segredo_d    = segredo_q;
        igual_d      = igual_q;
        perto_d      = perto_q;
        errada_d     = errada_q;
        maior_d      = maior_q;
        tentativas_d = tentativas_q;
        res_valido_d = 1'b0;

        if (nova_rodada) begin
            estado_d     = JOGANDO;
            segredo_d    = segredo;
            igual_d      = 1'b0;
            perto_d      = 1'b0;
            errada_d     = 1'b0;
            maior_d      = 1'b0;
            tentativas_d = '0;
        end else if ((estado_q == JOGANDO) && valido) begin
            igual_d      = dist_igual;
            perto_d      = dist_perto;
            errada_d     = dist_errada;
            maior_d      = dist_maior;
            tentativas_d = tentativas_q + CW'(1);
            res_valido_d = 1'b1;
            if (dist_igual) begin
                estado_d = GANHOU;
            end else if (tentativas_d == TENT_MAX) begin
                estado_d = PERDEU;
            end
        end
    end

    always_comb begin
        fim        = (estado_q == GANHOU) || (estado_q == PERDEU);
        venceu     = (estado_q == GANHOU);
        res_valido = res_valido_q;
        igual      = igual_q;
        perto      = perto_q;
        errada     = errada_q;
        maior      = maior_q;
        tentativas = tentativas_q;
    end

endmodule

// File: doc/comparador_rodada.md
COMPARADOR_RODADA -- requirements
Module: comparador_rodada

Interface
REQ-001 Parameter WIDTH, default 4, bit width of secret and guess (unsigned).
REQ-002 Parameter TOL, default 3, largest nonzero |guess-secret| classed "near"; range 0..2^WIDTH-1.
REQ-003 Parameter MAX_TENT, default 7, attempts allowed per round; at least 1.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port nova_rodada  input  1  one-cycle strobe: start a new round, latching segredo.
REQ-007 Port segredo  input  WIDTH  secret value; sampled only when nova_rodada=1.
REQ-008 Port valido  input  1  one-cycle strobe: palpite carries a guess.
REQ-009 Port palpite  input  WIDTH  guess value; sampled only when valido=1.
REQ-010 Port res_valido  output  1  one-cycle pulse: classification outputs updated.
REQ-011 Port igual  output  1  last guess equal to secret.
REQ-012 Port perto  output  1  last guess nonzero distance <= TOL.
REQ-013 Port errada  output  1  last guess distance > TOL.
REQ-014 Port maior  output  1  last guess greater than secret.
REQ-015 Port tentativas  output  $clog2(MAX_TENT+1)  attempts evaluated this round.
REQ-016 Port fim  output  1  round over (won or lost).
REQ-017 Port venceu  output  1  round ended by a correct guess.

Function
REQ-018 FSM states: OCIOSO, JOGANDO, GANHOU, PERDEU.
REQ-019 OCIOSO: valido ignored; nova_rodada -> JOGANDO.
REQ-020 nova_rodada in any state: latch segredo, clear tentativas to 0, clear igual/perto/errada/maior, go JOGANDO, no res_valido.
REQ-021 nova_rodada and valido in the same cycle: nova_rodada wins, guess discarded.
REQ-022 JOGANDO with valido=1: guess classified and registered; res_valido pulses the next cycle, in the same cycle the new classification appears (latency 1).
REQ-023 Distance: difference computed at WIDTH+1 bits signed, magnitude WIDTH bits; no wrap-around (0 vs 2^WIDTH-1 gives distance 2^WIDTH-1).
REQ-024 Exactly one of igual, perto, errada is 1 after any evaluation; with TOL=0 perto is never 1.
REQ-025 maior=1 iff palpite > segredo (unsigned); 0 when igual.
REQ-026 tentativas increments by 1 on every evaluated guess, winning guess included; it never exceeds MAX_TENT.
REQ-027 Evaluated guess with igual=1 -> GANHOU; otherwise, if tentativas reaches MAX_TENT -> PERDEU; otherwise stay in JOGANDO.
REQ-028 GANHOU/PERDEU: valido ignored, outputs hold, no res_valido; only nova_rodada leaves.
REQ-029 fim=1 in GANHOU or PERDEU; venceu=1 only in GANHOU; both are decoded from registered state (glitch-free).
REQ-030 Classification outputs hold their value between evaluations.

Reset
REQ-031 rst_n=0 forces OCIOSO immediately; all outputs 0, tentativas 0, latched secret 0.
REQ-032 Reset during JOGANDO discards any in-flight result; no res_valido after release.
REQ-033 First rising edge after rst_n deasserts obeys normal rules.

Structure
REQ-034 Shared package comparador_pkg holds the state enum and the classification-result encoding (IGUAL, PERTO, ERRADA).
REQ-035 Combinational sub-module comparador_dist (parameters WIDTH, TOL) computes distance, igual/perto/errada/maior; comparador_rodada registers its outputs.

Verification (WIDTH=4, TOL=3, MAX_TENT=4 unless stated)
REQ-036 nova_rodada secret 9; guess 9 -> next cycle res_valido=1, igual=1, tentativas=1, fim=1, venceu=1.
REQ-037 Secret 9; guesses 15, 11, 6, 2 -> errada/maior; perto/maior; perto/!maior; errada; after 4th, tentativas=4, fim=1, venceu=0; a 5th valido gives no res_valido.
REQ-038 Secret 0, guess 15 -> errada=1, maior=1 (no wrap); secret 15, guess 12 -> perto=1, maior=0.
REQ-039 nova_rodada with secret 5 and valido with guess 5 in the same cycle -> JOGANDO, tentativas=0, no res_valido.
REQ-040 rst_n pulsed low one cycle after valido -> all outputs 0 at once, no res_valido after release.
REQ-041 TOL=0, secret 7, guess 8 -> errada=1, perto=0.
